// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the memory port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IF_RD = 3'd1,
    ST_LS_RD = 3'd2,
    ST_LS_WR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_LSB = 1'b1
  } grant_t;

  localparam logic [1:0] SZ_BYTE       = 2'd0;
  localparam logic [1:0] SZ_HALF       = 2'd1;
  localparam logic [1:0] SZ_WORD       = 2'd2;
  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  // Size code 3 is folded onto a word access.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_byte_seq : walks a 1..4 byte little-endian access over the byte port
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_byte_seq
  import mem_arb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_en,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_n,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  input  logic [7:0]  i_mem_din,
  output logic [31:0] o_mem_a,
  output logic [7:0]  o_mem_dout,
  output logic        o_mem_wr,
  output logic        o_last,
  output logic [31:0] o_rdata
);

  logic        r_busy;
  logic [1:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;

  logic [1:0]  w_cnt_nxt;
  logic [31:0] w_rdata;

  assign w_cnt_nxt  = r_cnt + 2'd1;
  assign o_last     = r_busy && ({1'b0, r_cnt} == (r_n - 3'd1));
  assign o_mem_a    = r_mem_a;
  assign o_mem_dout = r_mem_dout;
  assign o_mem_wr   = r_mem_wr;
  assign o_rdata    = w_rdata;

  // The byte for the current address is on i_mem_din at the edge that retires it.
  always_comb begin
    w_rdata = r_buf;
    w_rdata[{r_cnt, 3'b000} +: 8] = i_mem_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy     <= 1'b0;
      r_cnt      <= 2'd0;
      r_n        <= 3'd0;
      r_base     <= 32'd0;
      r_wr       <= 1'b0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
    end else if (i_en) begin
      if (i_start) begin
        r_busy     <= 1'b1;
        r_cnt      <= 2'd0;
        r_n        <= i_n;
        r_base     <= i_addr;
        r_wr       <= i_wr;
        r_wdata    <= i_wdata;
        r_buf      <= 32'd0;
        r_mem_a    <= i_addr;
        r_mem_dout <= i_wdata[7:0];
        r_mem_wr   <= i_wr;
      end else if (r_busy) begin
        if (i_abort) begin
          r_busy   <= 1'b0;
          r_mem_wr <= 1'b0;
        end else if (o_last) begin
          r_busy   <= 1'b0;
          r_mem_wr <= 1'b0;
          r_buf    <= w_rdata;
        end else begin
          r_cnt      <= w_cnt_nxt;
          r_buf      <= w_rdata;
          r_mem_a    <= r_base + {30'd0, w_cnt_nxt};
          r_mem_dout <= r_wdata[{w_cnt_nxt, 3'b000} +: 8];
          r_mem_wr   <= r_wr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : shares the byte memory port between fetch and load/store
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [1:0] IO_HI    = IO_HI_DEFAULT,
  parameter int         IF_BYTES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [2:0] c_if_n = IF_BYTES[2:0];

  state_t      r_state;
  grant_t      r_last_grant;
  logic        r_if_done;
  logic        r_lsb_done;
  logic [31:0] r_if_data;
  logic [31:0] r_lsb_rdata;

  state_t      w_next_state;
  logic        w_start;
  logic        w_abort;
  logic        w_grant_lsb;
  logic        w_if_elig;
  logic        w_ls_elig;
  logic        w_finish;
  logic [31:0] w_seq_addr;
  logic [2:0]  w_seq_n;
  logic        w_seq_wr;
  logic        w_seq_mem_wr;
  logic        w_seq_last;
  logic [31:0] w_seq_rdata;

  // Stores into the IO window stall while the IO write buffer is full.
  assign w_if_elig = if_req;
  assign w_ls_elig = lsb_req &&
                     !(lsb_wr && io_buffer_full && (lsb_addr[17:16] == IO_HI));

  assign w_seq_addr = w_grant_lsb ? lsb_addr : if_addr;
  assign w_seq_n    = w_grant_lsb ? size_to_bytes(lsb_size) : c_if_n;
  assign w_seq_wr   = w_grant_lsb && lsb_wr;
  assign w_finish   = (w_next_state == ST_DONE) && (r_state != ST_DONE);

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_grant_lsb  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!clear && (w_if_elig || w_ls_elig)) begin
          w_start      = 1'b1;
          w_grant_lsb  = w_ls_elig && (!w_if_elig || (r_last_grant == GNT_IF));
          w_next_state = !w_grant_lsb ? ST_IF_RD : (lsb_wr ? ST_LS_WR : ST_LS_RD);
        end
      end
      ST_IF_RD, ST_LS_RD: begin
        if (clear) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_seq_last) begin
          w_next_state = ST_DONE;
        end
      end
      // A store already on the bus is committed and always runs to the end.
      ST_LS_WR: begin
        if (w_seq_last) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_IF;
    end else if (rdy_in) begin
      r_state <= w_next_state;
      if (w_start) r_last_grant <= w_grant_lsb ? GNT_LSB : GNT_IF;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_lsb_rdata <= 32'd0;
    end else if (rdy_in) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      if (w_finish) begin
        case (r_state)
          ST_IF_RD: begin
            r_if_done <= 1'b1;
            r_if_data <= w_seq_rdata;
          end
          ST_LS_RD: begin
            r_lsb_done  <= 1'b1;
            r_lsb_rdata <= w_seq_rdata;
          end
          default: r_lsb_done <= 1'b1;
        endcase
      end
    end
  end

  mem_byte_seq u_seq (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_en       (rdy_in),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .i_addr     (w_seq_addr),
    .i_n        (w_seq_n),
    .i_wr       (w_seq_wr),
    .i_wdata    (lsb_wdata),
    .i_mem_din  (mem_din),
    .o_mem_a    (mem_a),
    .o_mem_dout (mem_dout),
    .o_mem_wr   (w_seq_mem_wr),
    .o_last     (w_seq_last),
    .o_rdata    (w_seq_rdata)
  );

  // Gating with rdy_in keeps a frozen write cycle from landing twice.
  assign mem_wr    = w_seq_mem_wr & rdy_in;
  assign if_done   = r_if_done;
  assign if_data   = r_if_data;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed and randomized bench with a byte-memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_size = 2'd0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [7:0] ram     [0:1023];
  logic [7:0] ref_mem [0:1023];

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_size       (lsb_size),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 13) + (a >> 4) + 8'h5A);
  endfunction

  // Byte RAM aliased on the low 10 address bits; read data follows mem_a.
  assign mem_din = ram[mem_a[9:0]];

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
    end else if (mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
    end
  end

  always @(posedge clk_in) if (mem_wr) wr_count <= wr_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input bit is_if, input logic [1:0] sz);
    if (is_if) return 4;
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[10'(addr + 32'(i))];
    return v;
  endfunction

  // One access from a single requester; the DUT must be idle at the first edge.
  task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int clr_k, input int stall_k, input int stall_len);
    int n;
    int wr0;
    bit st;
    logic d;
    logic [31:0] exp;
    string nm;
    n   = nbytes(is_if, sz);
    st  = !is_if && wr;
    exp = model_read(addr, n);
    wr0 = wr_count;
    nm  = $sformatf("%s@%08h", is_if ? "if" : (wr ? "st" : "ld"), addr);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      lsb_req = 1'b1; lsb_wr = wr; lsb_size = sz; lsb_addr = addr; lsb_wdata = wdata;
    end
    for (int k = 0; k <= n; k++) begin
      @(posedge clk_in); #1;
      clear = 1'b0;
      d = is_if ? if_done : lsb_done;
      if (k < n) begin
        chk($sformatf("%s mem_a b%0d", nm, k), mem_a, addr + 32'(k));
        chk($sformatf("%s mem_wr b%0d", nm, k), 32'(mem_wr), 32'(st));
        if (st) chk($sformatf("%s mem_dout b%0d", nm, k), 32'(mem_dout), 32'(wdata[8*k +: 8]));
        chk($sformatf("%s early_done b%0d", nm, k), 32'(d), 32'd0);
        if (k == stall_k) begin
          rdy_in = 1'b0;
          repeat (stall_len) begin
            @(posedge clk_in); #1;
            chk($sformatf("%s stall mem_wr", nm), 32'(mem_wr), 32'd0);
            chk($sformatf("%s stall mem_a", nm), mem_a, addr + 32'(k));
            chk($sformatf("%s stall done", nm), 32'(is_if ? if_done : lsb_done), 32'd0);
          end
          rdy_in = 1'b1;
        end
        if (k == clr_k) clear = 1'b1;
      end else begin
        chk($sformatf("%s done", nm), 32'(d), 32'd1);
        chk($sformatf("%s mem_wr_after", nm), 32'(mem_wr), 32'd0);
        if (!st) chk($sformatf("%s data", nm), is_if ? if_data : lsb_rdata, exp);
      end
    end
    if_req = 1'b0;
    lsb_req = 1'b0;
    if (st) for (int i = 0; i < n; i++) ref_mem[10'(addr + 32'(i))] = wdata[8*i +: 8];
    chk($sformatf("%s write_count", nm), 32'(wr_count - wr0), st ? 32'(n) : 32'd0);
    @(posedge clk_in); #1;
    chk($sformatf("%s done_drop", nm), 32'(is_if ? if_done : lsb_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int wr0;
    bit r_if;
    bit r_wr;
    logic [1:0] r_sz;
    logic [31:0] r_addr;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;

    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_dout", 32'(mem_dout), 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset if_done", 32'(if_done), 32'd0);
    chk("reset lsb_done", 32'(lsb_done), 32'd0);
    chk("reset if_data", if_data, 32'd0);
    chk("reset lsb_rdata", lsb_rdata, 32'd0);

    // Simultaneous requests straight after reset: LSB wins, IF follows.
    if_req = 1'b1; if_addr = 32'h200;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h40;
    cyc = 0;
    while (!lsb_done && !if_done && cyc < 20) begin
      @(posedge clk_in); #1; cyc++;
    end
    chk("arb lsb_done first", 32'(lsb_done), 32'd1);
    chk("arb if_done quiet", 32'(if_done), 32'd0);
    chk("arb lsb latency edges", 32'(cyc), 32'd2);
    chk("arb lsb_rdata", lsb_rdata, model_read(32'h40, 1));
    lsb_req = 1'b0;
    cyc = 0;
    while (!if_done && cyc < 20) begin
      @(posedge clk_in); #1; cyc++;
    end
    chk("arb if after lsb edges", 32'(cyc), 32'd6);
    chk("arb if_data", if_data, model_read(32'h200, 4));
    if_req = 1'b0;
    @(posedge clk_in); #1;

    run_txn(1'b0, 1'b1, 2'd2, 32'h20, 32'hDEADBEEF, -1, -1, 0);
    run_txn(1'b0, 1'b0, 2'd2, 32'h20, 32'd0, -1, -1, 0);
    run_txn(1'b0, 1'b1, 2'd2, 32'h100, 32'h00000013, -1, -1, 0);
    run_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, -1, -1, 0);

    // Store into the IO window is held off while the IO buffer is full.
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h5A;
    if_req = 1'b1; if_addr = 32'h104;
    wr0 = wr_count;
    cyc = 0;
    while (!if_done && !lsb_done && cyc < 20) begin
      @(posedge clk_in); #1; cyc++;
    end
    chk("io if served edges", 32'(cyc), 32'd5);
    chk("io lsb held", 32'(lsb_done), 32'd0);
    chk("io if_data", if_data, model_read(32'h104, 4));
    if_req = 1'b0;
    repeat (3) begin
      @(posedge clk_in); #1;
      chk("io held mem_wr", 32'(mem_wr), 32'd0);
      chk("io held lsb_done", 32'(lsb_done), 32'd0);
    end
    chk("io held no writes", 32'(wr_count - wr0), 32'd0);
    io_buffer_full = 1'b0;
    cyc = 0;
    while (!lsb_done && cyc < 20) begin
      @(posedge clk_in); #1; cyc++;
    end
    chk("io store edges", 32'(cyc), 32'd2);
    chk("io store writes", 32'(wr_count - wr0), 32'd1);
    lsb_req = 1'b0;
    ref_mem[10'(32'h30000)] = 8'h5A;
    @(posedge clk_in); #1;
    io_buffer_full = 1'b1;
    run_txn(1'b0, 1'b0, 2'd0, 32'h30000, 32'd0, -1, -1, 0);
    io_buffer_full = 1'b0;

    // Flush while fetching byte 2: no completion, port free on the next edge.
    if_req = 1'b1; if_addr = 32'h180;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    chk("flush if mem_a", mem_a, 32'h182);
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
    if_req = 1'b0;
    chk("flush if no done", 32'(if_done), 32'd0);
    run_txn(1'b0, 1'b0, 2'd1, 32'h300, 32'd0, -1, -1, 0);

    run_txn(1'b0, 1'b1, 2'd2, 32'h0A0, 32'h11223344, 1, -1, 0);
    run_txn(1'b0, 1'b0, 2'd2, 32'h0A0, 32'd0, -1, -1, 0);
    run_txn(1'b0, 1'b1, 2'd2, 32'h2F0, 32'hCAFEF00D, -1, 1, 3);
    run_txn(1'b0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'd0, -1, -1, 0);

    for (int t = 0; t < 40; t++) begin
      r_if   = ($urandom_range(0, 2) == 0);
      r_wr   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                           : 32'($urandom);
      run_txn(r_if, r_wr, r_sz, r_addr, 32'($urandom), -1,
              ($urandom_range(0, 3) == 0) ? 0 : -1, $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
